// File: rtl/lock_responder_pkg.sv
// Shared command/ack encodings for the OmpSs manager and the lock responder state type.
package lock_responder_pkg;

    localparam int LOCK_ID_BITS = 8;
    localparam int LOCK_ID_L    = 8;
    localparam int LOCK_ID_H    = 15;
    localparam int ACK_LOCKID_L = 8;

    localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
    localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
    localparam logic [7:0] ACK_OK_CODE     = 8'h01;
    localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
    localparam logic [4:0] HWR_LOCK_ID     = 5'h15;

    typedef enum logic [1:0] {
        LOCK_IDLE,
        LOCK_DRAIN,
        LOCK_EXEC,
        LOCK_ACK
    } lock_state_e;

endpackage

// File: rtl/lock_responder_lock_table.sv
// Table of binary locks with per-lock owner; combinational read, single set/clear write port.
module lock_responder_lock_table #(
    parameter int LOCK_ID_BITS = lock_responder_pkg::LOCK_ID_BITS,
    parameter int ACC_BITS     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LOCK_ID_BITS-1:0] addr_i,
    output logic                    locked_o,
    output logic [ACC_BITS-1:0]     owner_o,
    input  logic                    wr_en_i,
    input  logic                    wr_set_i,
    input  logic [ACC_BITS-1:0]     wr_owner_i
);
    localparam int DEPTH = 1 << LOCK_ID_BITS;

    logic [DEPTH-1:0]    locked_vec;
    logic [ACC_BITS-1:0] owner_vec [DEPTH];

    // One register pair per entry so reset can clear the whole table in a single cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic                locked_q;
            logic [ACC_BITS-1:0] owner_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    locked_q <= 1'b0;
                    owner_q  <= '0;
                end else if (wr_en_i && (addr_i == LOCK_ID_BITS'(gi))) begin
                    locked_q <= wr_set_i;
                    if (wr_set_i) begin
                        owner_q <= wr_owner_i;
                    end
                end
            end

            assign locked_vec[gi] = locked_q;
            assign owner_vec[gi]  = owner_q;
        end
    endgenerate

    assign locked_o = locked_vec[addr_i];
    assign owner_o  = owner_vec[addr_i];

endmodule

// File: rtl/lock_responder.sv
// Lock/unlock command responder: decodes the first word of each command, updates the lock table, acks lock requests.
module lock_responder #(
    parameter int LOCK_ID_BITS = lock_responder_pkg::LOCK_ID_BITS,
    parameter int ACC_BITS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         inStream_tdata,
    input  logic                inStream_tvalid,
    output logic                inStream_tready,
    input  logic [ACC_BITS-1:0] inStream_tid,
    input  logic                inStream_tlast,
    output logic [63:0]         outStream_tdata,
    output logic                outStream_tvalid,
    input  logic                outStream_tready,
    output logic [ACC_BITS-1:0] outStream_tdest,
    output logic [4:0]          outStream_tid,
    output logic                outStream_tlast,
    output logic                err_pulse
);
    import lock_responder_pkg::*;

    lock_state_e             state_q, state_d;
    logic                    ready_q, ready_d;
    logic [7:0]              code_q, code_d;
    logic [LOCK_ID_BITS-1:0] lock_id_q, lock_id_d;
    logic [ACC_BITS-1:0]     tid_q, tid_d;
    logic [63:0]             data_q, data_d;
    logic [ACC_BITS-1:0]     dest_q, dest_d;

    logic                    tbl_locked;
    logic [ACC_BITS-1:0]     tbl_owner;
    logic                    tbl_wr_en;
    logic                    tbl_wr_set;
    logic                    err_d;
    logic                    in_hs;
    logic                    unused_tdata;

    // Only the code and lock id fields of the first word carry meaning.
    assign unused_tdata = ^inStream_tdata;
    assign in_hs        = inStream_tvalid & ready_q;

    lock_responder_lock_table #(
        .LOCK_ID_BITS(LOCK_ID_BITS),
        .ACC_BITS    (ACC_BITS)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (lock_id_q),
        .locked_o  (tbl_locked),
        .owner_o   (tbl_owner),
        .wr_en_i   (tbl_wr_en),
        .wr_set_i  (tbl_wr_set),
        .wr_owner_i(tid_q)
    );

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        lock_id_d  = lock_id_q;
        tid_d      = tid_q;
        data_d     = data_q;
        dest_d     = dest_q;
        tbl_wr_en  = 1'b0;
        tbl_wr_set = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            LOCK_IDLE: begin
                if (in_hs) begin
                    code_d    = inStream_tdata[7:0];
                    lock_id_d = inStream_tdata[LOCK_ID_L +: LOCK_ID_BITS];
                    tid_d     = inStream_tid;
                    state_d   = inStream_tlast ? LOCK_EXEC : LOCK_DRAIN;
                end
            end
            LOCK_DRAIN: begin
                if (in_hs && inStream_tlast) begin
                    state_d = LOCK_EXEC;
                end
            end
            LOCK_EXEC: begin
                if (code_q == CMD_LOCK_CODE) begin
                    // Locks are non-recursive: a held lock rejects even its own owner.
                    data_d                              = '0;
                    data_d[7:0]                         = tbl_locked ? ACK_REJECT_CODE : ACK_OK_CODE;
                    data_d[ACK_LOCKID_L +: LOCK_ID_BITS] = lock_id_q;
                    dest_d                              = tid_q;
                    tbl_wr_en                           = ~tbl_locked;
                    tbl_wr_set                          = 1'b1;
                    state_d                             = LOCK_ACK;
                end else if (code_q == CMD_UNLOCK_CODE) begin
                    if (tbl_locked && (tbl_owner == tid_q)) begin
                        tbl_wr_en = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = LOCK_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = LOCK_IDLE;
                end
            end
            LOCK_ACK: begin
                if (outStream_tready) begin
                    state_d = LOCK_IDLE;
                end
            end
            default: state_d = LOCK_IDLE;
        endcase
        ready_d = (state_d == LOCK_IDLE) || (state_d == LOCK_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOCK_IDLE;
            ready_q   <= 1'b0;
            code_q    <= '0;
            lock_id_q <= '0;
            tid_q     <= '0;
            data_q    <= '0;
            dest_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            code_q    <= code_d;
            lock_id_q <= lock_id_d;
            tid_q     <= tid_d;
            data_q    <= data_d;
            dest_q    <= dest_d;
        end
    end

    assign inStream_tready  = ready_q;
    assign outStream_tvalid = (state_q == LOCK_ACK);
    assign outStream_tdata  = data_q;
    assign outStream_tdest  = dest_q;
    assign outStream_tid    = HWR_LOCK_ID;
    assign outStream_tlast  = 1'b1;
    assign err_pulse        = err_d;

endmodule

// File: tb/tb_lock_responder.sv
// Self-checking bench for lock_responder: directed scenarios plus randomized commands against a lock-table model.
module tb_lock_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_tid;
    logic        in_last;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_dest;
    logic [4:0]  out_tid;
    logic        out_last;
    logic        err;

    always #5 clk = ~clk;

    lock_responder #(
        .LOCK_ID_BITS(8),
        .ACC_BITS    (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inStream_tdata  (in_data),
        .inStream_tvalid (in_valid),
        .inStream_tready (in_ready),
        .inStream_tid    (in_tid),
        .inStream_tlast  (in_last),
        .outStream_tdata (out_data),
        .outStream_tvalid(out_valid),
        .outStream_tready(out_ready),
        .outStream_tdest (out_dest),
        .outStream_tid   (out_tid),
        .outStream_tlast (out_last),
        .err_pulse       (err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: which ids are held and by whom.
    bit         m_locked [256];
    logic [7:0] m_owner  [256];

    // Observations of the last command run through run_cmd.
    bit          obs_got, obs_spurious, obs_stable, obs_rdylow, obs_timeout;
    logic [63:0] obs_data;
    logic [7:0]  obs_dest;
    logic [4:0]  obs_tid;
    logic        obs_last;
    int          obs_err;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            m_locked[i] = 1'b0;
            m_owner[i]  = 8'h00;
        end
    endtask

    task automatic model_cmd(input logic [7:0] code, input logic [7:0] id, input logic [7:0] tid,
                             output bit exp_ack, output logic [63:0] exp_data, output int exp_err);
        exp_ack  = 1'b0;
        exp_data = 64'h0;
        exp_err  = 0;
        if (code == 8'h04) begin
            exp_ack = 1'b1;
            if (m_locked[id]) begin
                exp_data = {48'h0, id, 8'h00};
            end else begin
                exp_data     = {48'h0, id, 8'h01};
                m_locked[id] = 1'b1;
                m_owner[id]  = tid;
            end
        end else if (code == 8'h06) begin
            if (m_locked[id] && m_owner[id] == tid) m_locked[id] = 1'b0;
            else exp_err = 1;
        end else begin
            exp_err = 1;
        end
    endtask

    task automatic run_cmd(input logic [7:0] code, input logic [7:0] id, input logic [7:0] tid,
                           input int nwords, input int hold);
        int n;
        obs_got = 0; obs_spurious = 0; obs_stable = 1; obs_rdylow = 1; obs_timeout = 0;
        obs_data = '0; obs_dest = '0; obs_tid = '0; obs_last = 0; obs_err = 0;
        out_ready = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            in_data  = (w == 0) ? {48'h0, id, code} : {$urandom, $urandom};
            in_tid   = tid;
            in_last  = (w == nwords - 1);
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && !obs_timeout) begin
                @(posedge clk); #1;
                n++;
                if (n > 50) obs_timeout = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        // EXEC cycle
        obs_err += int'(err);
        if (in_ready) obs_rdylow = 0;
        if (out_valid) obs_spurious = 1;
        @(posedge clk); #1;
        if (out_valid) begin
            obs_got  = 1;
            obs_data = out_data;
            obs_dest = out_dest;
            obs_tid  = out_tid;
            obs_last = out_last;
            for (int h = 0; h < hold; h++) begin
                if (!out_valid || out_data !== obs_data || out_dest !== obs_dest) obs_stable = 0;
                if (in_ready) obs_rdylow = 0;
                obs_err += int'(err);
                @(posedge clk); #1;
            end
            if (!out_valid || out_data !== obs_data || out_dest !== obs_dest) obs_stable = 0;
            if (in_ready) obs_rdylow = 0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (out_valid) obs_stable = 0;
        end else begin
            obs_err += int'(err);
            out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (out_valid) obs_spurious = 1;
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
        end
        $display("txn code=%h id=%h tid=%0d words=%0d ack=%0d data=%h dest=%0d err=%0d",
                 code, id, tid, nwords, obs_got, obs_data, obs_dest, obs_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_dest !== 8'h0) begin failures++; $display("FAIL reset_out_dest got=%h exp=0", out_dest); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (out_tid !== 5'h15) begin failures++; $display("FAIL reset_out_tid got=%h exp=15", out_tid); end
        checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL reset_out_last got=%b exp=1", out_last); end
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic test_lock_basic();
        bit e_ack; logic [63:0] e_data; int e_err;
        run_cmd(8'h04, 8'h2A, 8'd3, 1, 0);
        model_cmd(8'h04, 8'h2A, 8'd3, e_ack, e_data, e_err);
        checks++; if (obs_got !== e_ack || obs_spurious) begin failures++; $display("FAIL basic_ack_timing got=%b early=%b exp=%b", obs_got, obs_spurious, e_ack); end
        checks++; if (obs_data !== e_data) begin failures++; $display("FAIL basic_data got=%h exp=%h", obs_data, e_data); end
        checks++; if (obs_dest !== 8'd3) begin failures++; $display("FAIL basic_dest got=%0d exp=3", obs_dest); end
        checks++; if (obs_tid !== 5'h15 || obs_last !== 1'b1) begin failures++; $display("FAIL basic_tid_last got=%h/%b exp=15/1", obs_tid, obs_last); end
        checks++; if (obs_err !== e_err || obs_timeout) begin failures++; $display("FAIL basic_err got=%0d timeout=%0d exp=%0d", obs_err, obs_timeout, e_err); end
    endtask

    task automatic test_reject();
        bit e_ack; logic [63:0] e_data; int e_err;
        run_cmd(8'h04, 8'h2A, 8'd5, 1, 0);
        model_cmd(8'h04, 8'h2A, 8'd5, e_ack, e_data, e_err);
        checks++; if (obs_got !== e_ack || obs_data !== e_data) begin failures++; $display("FAIL reject_other got=%b/%h exp=%b/%h", obs_got, obs_data, e_ack, e_data); end
        checks++; if (obs_dest !== 8'd5) begin failures++; $display("FAIL reject_dest got=%0d exp=5", obs_dest); end
        run_cmd(8'h04, 8'h2A, 8'd3, 1, 0);
        model_cmd(8'h04, 8'h2A, 8'd3, e_ack, e_data, e_err);
        checks++; if (obs_data !== e_data) begin failures++; $display("FAIL reject_recursive got=%h exp=%h", obs_data, e_data); end
        run_cmd(8'h06, 8'h2A, 8'd5, 1, 0);
        model_cmd(8'h06, 8'h2A, 8'd5, e_ack, e_data, e_err);
        checks++; if (obs_err !== e_err || obs_got) begin failures++; $display("FAIL reject_owner_kept err=%0d ack=%b exp_err=%0d", obs_err, obs_got, e_err); end
    endtask

    task automatic test_unlock_relock();
        bit e_ack; logic [63:0] e_data; int e_err;
        run_cmd(8'h06, 8'h2A, 8'd3, 1, 0);
        model_cmd(8'h06, 8'h2A, 8'd3, e_ack, e_data, e_err);
        checks++; if (obs_got || obs_spurious || obs_err !== e_err) begin failures++; $display("FAIL unlock_silent ack=%b spur=%b err=%0d exp_err=%0d", obs_got, obs_spurious, obs_err, e_err); end
        run_cmd(8'h04, 8'h2A, 8'd5, 1, 0);
        model_cmd(8'h04, 8'h2A, 8'd5, e_ack, e_data, e_err);
        checks++; if (obs_data !== e_data || obs_dest !== 8'd5) begin failures++; $display("FAIL relock_data got=%h/%0d exp=%h/5", obs_data, obs_dest, e_data); end
    endtask

    task automatic test_errors();
        bit e_ack; logic [63:0] e_data; int e_err;
        run_cmd(8'h06, 8'h10, 8'd7, 1, 0);
        model_cmd(8'h06, 8'h10, 8'd7, e_ack, e_data, e_err);
        checks++; if (obs_err !== e_err || obs_got || obs_spurious) begin failures++; $display("FAIL err_free_unlock err=%0d ack=%b exp=%0d", obs_err, obs_got, e_err); end
        run_cmd(8'h09, 8'h10, 8'd7, 1, 0);
        model_cmd(8'h09, 8'h10, 8'd7, e_ack, e_data, e_err);
        checks++; if (obs_err !== e_err || obs_got || obs_spurious) begin failures++; $display("FAIL err_bad_code err=%0d ack=%b exp=%0d", obs_err, obs_got, e_err); end
        run_cmd(8'h04, 8'h10, 8'd7, 1, 0);
        model_cmd(8'h04, 8'h10, 8'd7, e_ack, e_data, e_err);
        checks++; if (obs_data !== e_data) begin failures++; $display("FAIL err_table_unchanged got=%h exp=%h", obs_data, e_data); end
    endtask

    task automatic test_multiword_backpressure();
        bit e_ack; logic [63:0] e_data; int e_err;
        run_cmd(8'h04, 8'hFF, 8'd2, 2, 5);
        model_cmd(8'h04, 8'hFF, 8'd2, e_ack, e_data, e_err);
        checks++; if (obs_got !== 1'b1 || obs_data !== e_data) begin failures++; $display("FAIL multi_data got=%b/%h exp=1/%h", obs_got, obs_data, e_data); end
        checks++; if (!obs_stable) begin failures++; $display("FAIL multi_stable got=0 exp=1"); end
        checks++; if (!obs_rdylow) begin failures++; $display("FAIL multi_ready_low got=0 exp=1"); end
    endtask

    task automatic test_reset_mid();
        bit e_ack; logic [63:0] e_data; int e_err;
        int n = 0;
        model_cmd(8'h04, 8'h01, 8'd4, e_ack, e_data, e_err);
        in_data = {48'h0, 8'h01, 8'h04}; in_tid = 8'd4; in_last = 1'b1; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== e_data) begin failures++; $display("FAIL rstmid_pending got=%b/%h exp=1/%h", out_valid, out_data, e_data); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid_drop got=%b exp=0", out_valid); end
        rst = 1'b0;
        model_clear();
        run_cmd(8'h04, 8'h01, 8'd9, 1, 0);
        model_cmd(8'h04, 8'h01, 8'd9, e_ack, e_data, e_err);
        checks++; if (obs_data !== e_data || obs_dest !== 8'd9) begin failures++; $display("FAIL rstmid_relock got=%h/%0d exp=%h/9", obs_data, obs_dest, e_data); end
        run_cmd(8'h04, 8'hFF, 8'd9, 1, 0);
        model_cmd(8'h04, 8'hFF, 8'd9, e_ack, e_data, e_err);
        checks++; if (obs_data !== e_data) begin failures++; $display("FAIL rstmid_table_cleared got=%h exp=%h", obs_data, e_data); end
    endtask

    task automatic test_random();
        bit e_ack; logic [63:0] e_data; int e_err;
        logic [7:0] ids [4];
        logic [7:0] code, id, tid;
        int r;
        ids[0] = 8'h2A; ids[1] = 8'h00; ids[2] = 8'hFF; ids[3] = 8'h5C;
        for (int it = 0; it < 60; it++) begin
            r    = $urandom_range(0, 9);
            code = (r < 5) ? 8'h04 : (r < 9) ? 8'h06 : 8'(8'h20 + $urandom_range(0, 15));
            id   = ids[$urandom_range(0, 3)];
            tid  = 8'($urandom_range(1, 3));
            run_cmd(code, id, tid, $urandom_range(1, 3), $urandom_range(0, 3));
            model_cmd(code, id, tid, e_ack, e_data, e_err);
            checks++;
            if (obs_got !== e_ack || obs_spurious || obs_timeout) begin
                failures++; $display("FAIL rand_ack it=%0d got=%b spur=%b to=%b exp=%b", it, obs_got, obs_spurious, obs_timeout, e_ack);
            end
            checks++;
            if (e_ack && (obs_data !== e_data || obs_dest !== tid)) begin
                failures++; $display("FAIL rand_data it=%0d got=%h/%0d exp=%h/%0d", it, obs_data, obs_dest, e_data, tid);
            end
            checks++;
            if (obs_err !== e_err) begin
                failures++; $display("FAIL rand_err it=%0d got=%0d exp=%0d", it, obs_err, e_err);
            end
            checks++;
            if (!obs_stable || !obs_rdylow) begin
                failures++; $display("FAIL rand_handshake it=%0d stable=%b ready_low=%b exp=1/1", it, obs_stable, obs_rdylow);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_tid = '0; in_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_lock_basic();
        test_reject();
        test_unlock_relock();
        test_errors();
        test_multiword_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
